// File: rtl/ccd_clock_sequencer_gen2.sv
// CCD clock sequencer: four-phase CCD clock generator with tick prescaler,
// shadowed frame configuration and a Wishbone register window.
`timescale 1ns/1ps
module ccd_clock_sequencer_gen2 #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          PIX_W       = 14,
  parameter int          INTEG_W     = 32,
  parameter int          FRAME_W     = 16,
  parameter int          CYC_PER_PIX = 8,
  parameter int          PIXELS_DEF  = 2052,
  parameter int          PHI_P_W_DEF = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ext_trig_i,
  output logic        phi_p_o,
  output logic        phi_l1_o,
  output logic        phi_l2_o,
  output logic        phi_r_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int KW = $clog2(CYC_PER_PIX);
  localparam logic [KW-1:0] K_HALF = KW'(CYC_PER_PIX / 2);
  localparam logic [KW-1:0] K_3Q   = KW'(3 * CYC_PER_PIX / 4);
  localparam logic [3:0]    PH_PP  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PULSE = 3'd4
  } state_t;

  state_t state;

  logic               ctrl_en, ctrl_trig_en, done_sticky;
  logic [PIX_W-1:0]   pixels, w_pixels, pix_cnt;
  logic [INTEG_W-1:0] integ, w_integ, seg_cnt, seg_lim;
  logic [15:0]        prescale, w_prescale, presc_cnt;
  logic [7:0]         pwidth, w_pwidth;
  logic [FRAME_W-1:0] frames, frame_cnt, fcnt_inc;
  logic [KW-1:0]      k_cnt;
  logic [3:0]         ph;
  logic [31:0]        wmask, rdata;
  logic [2:0]         ofs;
  logic               trig_s1, trig_s2, trig_s3;
  logic               in_win, wb_go, wr, ctrl_wr, sts_clr;
  logic               start_wr, abort_wr, en_eff, trig_rise;
  logic               start_req, abort_req, tick, seg_end;
  logic               pix_last, k_last, last_frame;
  logic               fin, nxt_frame, load_shadow;
  logic [1:0]         unused_adr;

  function automatic logic [31:0] bmerge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [31:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  function automatic logic [3:0] shift_ph(input logic [KW-1:0] k);
    return {1'b0, k < K_HALF, k >= K_HALF, (k >= K_HALF) && (k < K_3Q)};
  endfunction

  assign unused_adr = wbs_adr_i[1:0];
  assign in_win  = wbs_adr_i[31:5] == BASE_ADDR[31:5];
  assign wb_go   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & in_win;
  assign wr      = wb_go & wbs_we_i;
  assign ofs     = wbs_adr_i[4:2];
  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign ctrl_wr = wr && ofs == 3'd0 && wbs_sel_i[0];
  assign sts_clr = wr && ofs == 3'd6 && wbs_sel_i[0] && wbs_dat_i[1];

  assign start_wr  = ctrl_wr & wbs_dat_i[2];
  assign abort_wr  = ctrl_wr & wbs_dat_i[3];
  assign en_eff    = ctrl_wr ? wbs_dat_i[0] : ctrl_en;
  assign trig_rise = trig_s2 & ~trig_s3 & ctrl_trig_en;
  assign start_req = (start_wr | trig_rise) & en_eff & ~abort_wr;
  assign abort_req = abort_wr | ~en_eff;

  assign tick     = (state != ST_IDLE) && (presc_cnt == w_prescale);
  assign seg_lim  = (state == ST_HOLD) ? w_integ : INTEG_W'(w_pwidth);
  assign seg_end  = seg_cnt == seg_lim - 1'b1;
  assign pix_last = pix_cnt == w_pixels - 1'b1;
  assign k_last   = &k_cnt;
  assign fcnt_inc = frame_cnt + 1'b1;
  assign last_frame = (frames != '0) && (fcnt_inc == frames);

  // Abort has priority over frame completion in PULSE.
  assign fin = tick && state == ST_PULSE && seg_end &&
               last_frame && !abort_req;
  assign nxt_frame = tick && state == ST_PULSE && seg_end &&
                     !last_frame && !abort_req;
  assign load_shadow = (state == ST_IDLE && start_req) || nxt_frame;

  assign busy_o   = state != ST_IDLE;
  assign phi_p_o  = ph[3];
  assign phi_l1_o = ph[2];
  assign phi_l2_o = ph[1];
  assign phi_r_o  = ph[0];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= ext_trig_i;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ctrl_en      <= 1'b0;
      ctrl_trig_en <= 1'b0;
      pixels       <= PIX_W'(PIXELS_DEF);
      integ        <= '0;
      prescale     <= '0;
      pwidth       <= 8'(PHI_P_W_DEF);
      frames       <= FRAME_W'(1);
      done_sticky  <= 1'b0;
    end else begin
      if (wr) begin
        case (ofs)
          3'd0: if (wbs_sel_i[0]) begin
            ctrl_en      <= wbs_dat_i[0];
            ctrl_trig_en <= wbs_dat_i[1];
          end
          3'd1: pixels <= PIX_W'(bmerge(32'(pixels), wbs_dat_i, wmask));
          3'd2: integ <= INTEG_W'(bmerge(32'(integ), wbs_dat_i, wmask));
          3'd3: prescale <= 16'(bmerge(32'(prescale), wbs_dat_i, wmask));
          3'd4: pwidth <= 8'(bmerge(32'(pwidth), wbs_dat_i, wmask));
          3'd5: frames <= FRAME_W'(bmerge(32'(frames), wbs_dat_i, wmask));
          default: ;
        endcase
      end
      if (fin)
        done_sticky <= 1'b1;
      else if (sts_clr)
        done_sticky <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (ofs)
      3'd0: rdata = {30'd0, ctrl_trig_en, ctrl_en};
      3'd1: rdata = 32'(pixels);
      3'd2: rdata = 32'(integ);
      3'd3: rdata = 32'(prescale);
      3'd4: rdata = 32'(pwidth);
      3'd5: rdata = 32'(frames);
      3'd6: rdata = {27'd0, state, done_sticky, busy_o};
      3'd7: rdata = 32'(frame_cnt);
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_go;
      if (wb_go)
        wbs_dat_o <= rdata;
    end
  end

  // Zero-valued settings are clamped to one when latched.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      w_pixels   <= '0;
      w_integ    <= '0;
      w_pwidth   <= '0;
      w_prescale <= '0;
    end else if (load_shadow) begin
      w_pixels   <= (pixels == '0) ? PIX_W'(1) : pixels;
      w_integ    <= (integ == '0) ? INTEG_W'(1) : integ;
      w_pwidth   <= (pwidth == '0) ? 8'd1 : pwidth;
      w_prescale <= prescale;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || state == ST_IDLE || tick)
      presc_cnt <= '0;
    else
      presc_cnt <= presc_cnt + 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      ph        <= '0;
      irq_o     <= 1'b0;
      seg_cnt   <= '0;
      pix_cnt   <= '0;
      k_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      irq_o <= 1'b0;
      if (state != ST_IDLE && abort_req) begin
        state <= ST_IDLE;
        ph    <= '0;
      end else begin
        unique case (state)
          ST_IDLE: if (start_req) begin
            state     <= ST_PRE;
            ph        <= PH_PP;
            frame_cnt <= '0;
            seg_cnt   <= '0;
          end
          ST_PRE: if (tick) begin
            if (seg_end) begin
              state   <= ST_SHIFT;
              ph      <= shift_ph('0);
              k_cnt   <= '0;
              pix_cnt <= '0;
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          ST_SHIFT: if (tick) begin
            k_cnt <= k_cnt + 1'b1;
            ph    <= shift_ph(k_cnt + 1'b1);
            if (k_last) begin
              pix_cnt <= pix_cnt + 1'b1;
              if (pix_last) begin
                state   <= ST_HOLD;
                ph      <= '0;
                seg_cnt <= '0;
              end
            end
          end
          ST_HOLD: if (tick) begin
            if (seg_end) begin
              state   <= ST_PULSE;
              ph      <= PH_PP;
              seg_cnt <= '0;
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          ST_PULSE: if (tick) begin
            if (seg_end) begin
              frame_cnt <= fcnt_inc;
              seg_cnt   <= '0;
              if (last_frame) begin
                state <= ST_IDLE;
                ph    <= '0;
                irq_o <= 1'b1;
              end else begin
                state   <= ST_SHIFT;
                ph      <= shift_ph('0);
                k_cnt   <= '0;
                pix_cnt <= '0;
              end
            end else begin
              seg_cnt <= seg_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
